key_debounce_n: RTL

Parametrised multi-key debouncer and event generator that replaces the fixed 4-key, priority-encoded key block in the panel front end. Each of NUM_KEYS inputs has its own synchroniser, debounce state machine and hold timer. Each key produces a clean level plus single-cycle press, release, long-press and auto-repeat pulses. All keys run concurrently, so simultaneous presses are all reported, with no priority masking. Consumers are the menu/control FSMs and the LED status logic.

---
 rtl/key_debounce_n_if.sv | 22 ++
 rtl/key_debounce_n.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/key_debounce_n_if.sv
// Key pins and the debounced level/event outputs of the multi-key debouncer.
interface key_debounce_n_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;
    logic [NUM_KEYS-1:0] key_repeat;
    logic                any_pressed;

    modport master (
        output key_in,
        input  key_level, key_press, key_release, key_long, key_repeat, any_pressed
    );

    modport slave (
        input  key_in,
        output key_level, key_press, key_release, key_long, key_repeat, any_pressed
    );
endinterface

// File: rtl/key_debounce_n.sv
// Parametrised multi-key debouncer: per-key synchroniser, debounce FSM and hold
// timer producing a clean level plus press/release/long/repeat pulses.
module key_debounce_n #(
    parameter int NUM_KEYS    = 4,
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    key_debounce_n_if.slave keys
);
    localparam int PRESCALE = CLK_FREQ / 1000;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW = $clog2(LONG_MS + 1);
    localparam int RW = (REPEAT_MS > 0) ? $clog2(REPEAT_MS + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_MS);
    localparam logic [RW-1:0] RPT_LAST  = (REPEAT_MS > 0) ? RW'(REPEAT_MS - 1) : '0;
    localparam logic          RPT_EN    = (REPEAT_MS > 0);
    localparam logic          REL_LVL   = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

    logic [PW-1:0]       pre_cnt;
    logic                tick;
    logic [NUM_KEYS-1:0] level_v, level_nxt_v, press_v, rel_v, long_v, rpt_v;
    logic                any_q;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_cnt <= '0;
            any_q   <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            any_q   <= |level_nxt_v;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic          sync1, sync2, raw_p;
        state_t        state, state_nxt;
        logic [DW-1:0] deb_cnt, deb_nxt;
        logic [HW-1:0] hold_cnt, hold_nxt;
        logic [RW-1:0] rpt_cnt, rpt_nxt;
        logic          press_nxt, rel_nxt, long_nxt, rpt_evt_nxt, level_nxt;
        logic          level_q, press_q, rel_q, long_q, rpt_q;

        assign raw_p     = REL_LVL ? ~sync2 : sync2;
        assign level_nxt = (state_nxt == PRESSED) || (state_nxt == DEB_REL);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync1    <= REL_LVL;
                sync2    <= REL_LVL;
                state    <= IDLE;
                deb_cnt  <= '0;
                hold_cnt <= '0;
                rpt_cnt  <= '0;
                level_q  <= 1'b0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                long_q   <= 1'b0;
                rpt_q    <= 1'b0;
            end else begin
                sync1    <= keys.key_in[i];
                sync2    <= sync1;
                state    <= state_nxt;
                deb_cnt  <= deb_nxt;
                hold_cnt <= hold_nxt;
                rpt_cnt  <= rpt_nxt;
                level_q  <= level_nxt;
                press_q  <= press_nxt;
                rel_q    <= rel_nxt;
                long_q   <= long_nxt;
                rpt_q    <= rpt_evt_nxt;
            end
        end

        always_comb begin
            state_nxt   = state;
            deb_nxt     = deb_cnt;
            hold_nxt    = hold_cnt;
            rpt_nxt     = rpt_cnt;
            press_nxt   = 1'b0;
            rel_nxt     = 1'b0;
            long_nxt    = 1'b0;
            rpt_evt_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (raw_p) begin
                        state_nxt = DEB_PRESS;
                        deb_nxt   = '0;
                    end
                end
                DEB_PRESS: begin
                    if (!raw_p) begin
                        state_nxt = IDLE;
                    end else if (tick) begin
                        deb_nxt = deb_cnt + DW'(1);
                        if (deb_cnt == DEB_LAST) begin
                            state_nxt = PRESSED;
                            press_nxt = 1'b1;
                            hold_nxt  = '0;
                            rpt_nxt   = '0;
                        end
                    end
                end
                PRESSED: begin
                    // hold/repeat counters stay frozen across a release glitch
                    if (!raw_p) begin
                        state_nxt = DEB_REL;
                        deb_nxt   = '0;
                    end else if (tick) begin
                        if (hold_cnt != HOLD_MAX) begin
                            hold_nxt = hold_cnt + HW'(1);
                            long_nxt = (hold_cnt == HOLD_LAST);
                        end else if (RPT_EN) begin
                            if (rpt_cnt == RPT_LAST) begin
                                rpt_evt_nxt = 1'b1;
                                rpt_nxt     = '0;
                            end else begin
                                rpt_nxt = rpt_cnt + RW'(1);
                            end
                        end
                    end
                end
                DEB_REL: begin
                    if (raw_p) begin
                        state_nxt = PRESSED;
                    end else if (tick) begin
                        deb_nxt = deb_cnt + DW'(1);
                        if (deb_cnt == DEB_LAST) begin
                            state_nxt = IDLE;
                            rel_nxt   = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign level_nxt_v[i] = level_nxt;
        assign level_v[i]     = level_q;
        assign press_v[i]     = press_q;
        assign rel_v[i]       = rel_q;
        assign long_v[i]      = long_q;
        assign rpt_v[i]       = rpt_q;
    end

    assign keys.key_level   = level_v;
    assign keys.key_press   = press_v;
    assign keys.key_release = rel_v;
    assign keys.key_long    = long_v;
    assign keys.key_repeat  = rpt_v;
    assign keys.any_pressed = any_q;
endmodule
